// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave backed by a word-addressed SRAM; read and write FSMs run independently.
// Define AXI_SLAVE_DELAY_EN to insert RD_DELAY / WR_DELAY wait states before rvalid / bvalid.
module axi_sram_slave #(
    parameter int    MEM_AW    = 12,
    parameter string INIT_FILE = "",
    parameter int    RD_DELAY  = 0,
    parameter int    WR_DELAY  = 0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam logic [1:0] R_IDLE = 2'd0, R_DATA = 2'd1;
    localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
`ifdef AXI_SLAVE_DELAY_EN
    localparam logic [1:0] R_WAIT = 2'd2, W_WAIT = 2'd3;
    logic [7:0] rwait, wwait;
`endif

    logic [31:0] mem [0:(1<<MEM_AW)-1];
    logic [1:0] rstate, wstate;
    logic [MEM_AW-1:0] raddr, waddr, raddr_next, ar_word;
    logic [7:0] rlen, wlen, rcnt;
    logic [8:0] wcnt;
    logic rerr, rincr, werr, wincr, bad;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, ar_err, aw_err, wr_en;
    logic unused;

    assign ar_hs      = arvalid && arready;
    assign r_hs       = rvalid && rready;
    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;
    assign b_hs       = bvalid && bready;
    assign ar_err     = arsize != 3'b010 || arburst[1];
    assign aw_err     = awsize != 3'b010 || awburst[1];
    assign ar_word    = araddr[MEM_AW+1:2];
    assign raddr_next = rincr ? raddr + MEM_AW'(1) : raddr;
    assign rvalid     = rstate == R_DATA;
    assign rlast      = rvalid && rcnt == rlen;
    assign rresp      = {rvalid && rerr, 1'b0};
    assign wready     = wstate == W_DATA;
    assign bvalid     = wstate == W_RESP;
    assign bresp      = {bvalid && bad, 1'b0};
    // 9-bit saturating write counter so beats past awlen=255 are still discarded
    assign wr_en      = w_hs && !werr && !wcnt[8] && wcnt[7:0] <= wlen;
    assign unused     = ^{araddr[31:MEM_AW+2], araddr[1:0], arlock, arcache, arprot, awaddr[31:MEM_AW+2],
                          awaddr[1:0], awlock, awcache, awprot, wid, RD_DELAY[0], WR_DELAY[0]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate  <= R_IDLE;
            arready <= 1'b0;
            rid     <= '0;
            raddr   <= '0;
            rlen    <= '0;
            rcnt    <= '0;
            rerr    <= 1'b0;
            rincr   <= 1'b0;
            rdata   <= '0;
`ifdef AXI_SLAVE_DELAY_EN
            rwait   <= '0;
`endif
        end else begin
            arready <= rstate == R_IDLE && !ar_hs;
            case (rstate)
                R_IDLE: if (ar_hs) begin
                    rid   <= arid;
                    raddr <= ar_word;
                    rlen  <= arlen;
                    rcnt  <= '0;
                    rerr  <= ar_err;
                    rincr <= arburst == 2'b01;
`ifdef AXI_SLAVE_DELAY_EN
                    if (RD_DELAY > 0) begin
                        rstate <= R_WAIT;
                        rwait  <= 8'(RD_DELAY - 1);
                    end else begin
                        rstate <= R_DATA;
                        rdata  <= ar_err ? '0 : mem[ar_word];
                    end
`else
                    rstate <= R_DATA;
                    rdata  <= ar_err ? '0 : mem[ar_word];
`endif
                end
`ifdef AXI_SLAVE_DELAY_EN
                R_WAIT: if (rwait == 8'd0) begin
                    rstate <= R_DATA;
                    rdata  <= rerr ? '0 : mem[raddr];
                end else rwait <= rwait - 8'd1;
`endif
                R_DATA: if (r_hs) begin
                    rcnt  <= rcnt + 8'd1;
                    raddr <= raddr_next;
                    rdata <= rerr ? '0 : mem[raddr_next];
                    if (rlast) rstate <= R_IDLE;
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate  <= W_IDLE;
            awready <= 1'b0;
            bid     <= '0;
            waddr   <= '0;
            wlen    <= '0;
            wcnt    <= '0;
            werr    <= 1'b0;
            wincr   <= 1'b0;
            bad     <= 1'b0;
`ifdef AXI_SLAVE_DELAY_EN
            wwait   <= '0;
`endif
        end else begin
            awready <= wstate == W_IDLE && !aw_hs;
            case (wstate)
                W_IDLE: if (aw_hs) begin
                    bid    <= awid;
                    waddr  <= awaddr[MEM_AW+1:2];
                    wlen   <= awlen;
                    wcnt   <= '0;
                    werr   <= aw_err;
                    wincr  <= awburst == 2'b01;
                    wstate <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    wcnt  <= wcnt + {8'd0, !wcnt[8]};
                    waddr <= wincr ? waddr + MEM_AW'(1) : waddr;
                    if (wlast) begin
                        bad <= werr || wcnt != {1'b0, wlen};
`ifdef AXI_SLAVE_DELAY_EN
                        wstate <= WR_DELAY > 0 ? W_WAIT : W_RESP;
                        wwait  <= 8'(WR_DELAY - 1);
`else
                        wstate <= W_RESP;
`endif
                    end
                end
`ifdef AXI_SLAVE_DELAY_EN
                W_WAIT: if (wwait == 8'd0) wstate <= W_RESP;
                        else wwait <= wwait - 8'd1;
`endif
                W_RESP: if (b_hs) wstate <= W_IDLE;
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en)
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule
